// File: rtl/writeback_arbiter_pkg.sv
// Shared types and default sizing for the writeback arbiter slice.
package wb_pkg;
  localparam int DATA_WIDTH_DEF   = 20;
  localparam int REG_NUMBER_DEF   = 5;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef struct packed {
    logic [REG_NUMBER_DEF-1:0] rd;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU/load inputs, register-file write port and status for the arbiter.
interface writeback_arbiter_if
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int REG_NUMBER   = REG_NUMBER_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Load handshake: a transfer happens on a clock edge where mem_valid and
  // mem_ready are both high; the source holds mem_rd/mem_data until then.
  // The ALU has no ready; the source must hold results while alu_stall is high.
  logic                     alu_valid;
  logic [REG_NUMBER-1:0]    alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     alu_stall;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [REG_NUMBER-1:0]    mem_rd;
  logic [DATA_WIDTH-1:0]    mem_data;
  logic                     wb_reg_write;
  logic [REG_NUMBER-1:0]    wb_rd;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic [2**REG_NUMBER-1:0] pending_mask;
  logic                     err;
  logic [CW-1:0]            dbg_count;
  logic [SW-1:0]            dbg_starve;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_stall, mem_ready, wb_reg_write, wb_rd, wb_data, pending_mask, err,
           dbg_count, dbg_starve
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_stall, mem_ready, wb_reg_write, wb_rd, wb_data, pending_mask, err,
           dbg_count, dbg_starve
  );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Load-result queue: power-of-two ring buffer with per-slot occupancy for the pending mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  parameter int  RW    = REG_NUMBER_DEF,
  parameter type T     = wb_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  T                 wr_entry,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [RW-1:0]    entry_rd [DEPTH],
  output logic [DEPTH-1:0] occupied
);
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  T              mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign entry_rd[g] = mem[g].rd;
  end

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      occupied <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr           <= wr_ptr + 1'b1;
        occupied[wr_ptr] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr           <= rd_ptr + 1'b1;
        occupied[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and queued load results onto a single registered register-file write port.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int REG_NUMBER   = REG_NUMBER_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Local entry type so non-default widths still line up with the bus.
  typedef struct packed {
    logic [REG_NUMBER-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                   head;
  entry_t                   wr_entry;
  logic [REG_NUMBER-1:0]    entry_rd [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    occupied;
  logic [CW-1:0]            count;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     stall;
  logic                     alu_win;
  logic [SW-1:0]            starve;
  logic                     err_q;
  logic                     we_q;
  logic [REG_NUMBER-1:0]    rd_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [2**REG_NUMBER-1:0] mask;

  assign stall    = (starve == SW'(STARVE_LIMIT)) && !empty;
  assign alu_win  = bus.alu_valid && !stall;
  assign pop      = !empty && !alu_win;
  // Loads to r0 complete the handshake but never occupy a slot.
  assign push     = bus.mem_valid && !full && (bus.mem_rd != '0);
  assign wr_entry = '{rd: bus.mem_rd, data: bus.mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .RW    (REG_NUMBER),
    .T     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .entry_rd (entry_rd),
    .occupied (occupied)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (alu_win) begin
      we_q <= (bus.alu_rd != '0);
      if (bus.alu_rd != '0) begin
        rd_q   <= bus.alu_rd;
        data_q <= bus.alu_data;
      end
    end else if (pop) begin
      we_q   <= 1'b1;
      rd_q   <= head.rd;
      data_q <= head.data;
    end else begin
      we_q <= 1'b0;
    end
  end

  // Counts ALU wins that left loads waiting; any pop or an empty queue resets it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve <= '0;
    end else if (empty || pop) begin
      starve <= '0;
    end else if (alu_win && starve != SW'(STARVE_LIMIT)) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (bus.alu_valid && stall) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (occupied[i]) mask[entry_rd[i]] = 1'b1;
    end
  end

  assign bus.alu_stall    = stall;
  assign bus.mem_ready    = !full;
  assign bus.wb_reg_write = we_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = data_q;
  assign bus.pending_mask = mask;
  assign bus.err          = err_q;
  assign bus.dbg_count    = count;
  assign bus.dbg_starve   = starve;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scenario bench for writeback_arbiter: scripted ALU/load traffic against an expected-write queue.
module tb_writeback_arbiter;
  localparam int DW = 20;
  localparam int RN = 5;
  localparam int FD = 4;
  localparam int SL = 3;
  localparam int EW = RN + DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] exp_v;

  always #5 clk = ~clk;

  writeback_arbiter_if #(
    .DATA_WIDTH(DW), .REG_NUMBER(RN), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)
  ) bus ();

  writeback_arbiter #(
    .DATA_WIDTH(DW), .REG_NUMBER(RN), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Every register-file write must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (bus.wb_reg_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write rd=%0d data=%h, want no write", bus.wb_rd, bus.wb_data);
      end else begin
        exp_v = exp_q.pop_front();
        if ({bus.wb_rd, bus.wb_data} !== exp_v) begin
          errors++;
          $display("FAIL wb_write: got rd=%0d data=%h, want rd=%0d data=%h",
                   bus.wb_rd, bus.wb_data, exp_v[EW-1:DW], exp_v[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
  endtask

  task automatic test_reset();
    logic [31:0] zero_mask;
    zero_mask = '0;
    idle_inputs();
    rst = 1'b0;
    repeat (3) step();
    checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.wb_reg_write); end
    checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", bus.wb_rd); end
    checks++; if (bus.wb_data !== 20'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.wb_data); end
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b want 1", bus.mem_ready); end
    checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.alu_stall); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.pending_mask !== zero_mask) begin errors++; $display("FAIL reset_mask: got %h want 0", bus.pending_mask); end
    checks++; if (bus.dbg_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.dbg_count); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu_basic();
    logic [RN-1:0] rd;
    logic [DW-1:0] data;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 20'h00ABC;
    exp_q.push_back({5'd3, 20'h00ABC});
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_we: got %b want 1", bus.wb_reg_write); end
    checks++; if (bus.wb_rd !== 5'd3) begin errors++; $display("FAIL alu_rd: got %0d want 3", bus.wb_rd); end
    checks++; if (bus.wb_data !== 20'h00ABC) begin errors++; $display("FAIL alu_data: got %h want 00abc", bus.wb_data); end
    step();
    checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL idle_we: got %b want 0", bus.wb_reg_write); end
    checks++; if ({bus.wb_rd, bus.wb_data} !== {5'd3, 20'h00ABC}) begin
      errors++; $display("FAIL idle_hold: got rd=%0d data=%h want rd=3 data=00abc", bus.wb_rd, bus.wb_data);
    end
    for (int k = 0; k < 4; k++) begin
      rd   = RN'($urandom_range(1, (1 << RN) - 1));
      data = DW'($urandom());
      bus.alu_valid = 1'b1;
      bus.alu_rd    = rd;
      bus.alu_data  = data;
      exp_q.push_back({rd, data});
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_load_single();
    logic [31:0] m;
    m = 32'h0000_0020;
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", bus.mem_ready); end
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd5;
    bus.mem_data  = 20'h12345;
    step();
    bus.mem_valid = 1'b0;
    checks++; if (bus.pending_mask !== m) begin errors++; $display("FAIL load_mask_set: got %h want %h", bus.pending_mask, m); end
    checks++; if (bus.dbg_count !== 3'd1) begin errors++; $display("FAIL load_count: got %0d want 1", bus.dbg_count); end
    exp_q.push_back({5'd5, 20'h12345});
    step();
    m = '0;
    checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 20'h12345) begin
      errors++; $display("FAIL load_write: got we=%b rd=%0d data=%h want we=1 rd=5 data=12345", bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    end
    checks++; if (bus.pending_mask !== m) begin errors++; $display("FAIL load_mask_clear: got %h want 0", bus.pending_mask); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] ld [5];
    logic [EW-1:0] al [6];
    logic [31:0]   m;
    for (int i = 0; i < 5; i++) ld[i] = {RN'(6 + i), DW'($urandom())};
    for (int i = 0; i < 6; i++) al[i] = {RN'($urandom_range(1, (1 << RN) - 1)), DW'($urandom())};
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.mem_ready); end
      checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL b2b_nostall_%0d: got %b want 0", i, bus.alu_stall); end
      bus.alu_valid = 1'b1; {bus.alu_rd, bus.alu_data} = al[i];
      bus.mem_valid = 1'b1; {bus.mem_rd, bus.mem_data} = ld[i];
      exp_q.push_back(al[i]);
      step();
    end
    m = 32'h0000_03C0;
    checks++; if (bus.dbg_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count: got %0d want 4", bus.dbg_count); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", bus.mem_ready); end
    checks++; if (bus.alu_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b want 1", bus.alu_stall); end
    checks++; if (bus.dbg_starve !== 2'd3) begin errors++; $display("FAIL b2b_starve: got %0d want 3", bus.dbg_starve); end
    checks++; if (bus.pending_mask !== m) begin errors++; $display("FAIL b2b_mask: got %h want %h", bus.pending_mask, m); end
    // ALU keeps driving through the stall: its result must be dropped.
    {bus.alu_rd, bus.alu_data} = al[4];
    {bus.mem_rd, bus.mem_data} = ld[4];
    exp_q.push_back(ld[0]);
    step();
    checks++; if ({bus.wb_rd, bus.wb_data} !== ld[0]) begin errors++; $display("FAIL b2b_head_wins: got %h want %h", {bus.wb_rd, bus.wb_data}, ld[0]); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL b2b_err_set: got %b want 1", bus.err); end
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b want 1", bus.mem_ready); end
    checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_clear: got %b want 0", bus.alu_stall); end
    checks++; if (bus.dbg_count !== 3'd3) begin errors++; $display("FAIL b2b_count_pop: got %0d want 3", bus.dbg_count); end
    {bus.alu_rd, bus.alu_data} = al[5];
    exp_q.push_back(al[5]);
    step();
    idle_inputs();
    checks++; if (bus.dbg_count !== 3'd4) begin errors++; $display("FAIL b2b_refill: got %0d want 4", bus.dbg_count); end
    for (int i = 1; i < 5; i++) begin
      exp_q.push_back(ld[i]);
      step();
    end
    checks++; if (bus.dbg_count !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", bus.dbg_count); end
    step();
    checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL b2b_idle_we: got %b want 0", bus.wb_reg_write); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL b2b_err_sticky: got %b want 1", bus.err); end
  endtask

  task automatic test_rd_zero();
    logic [31:0] zero_mask;
    zero_mask = '0;
    bus.alu_valid = 1'b1; bus.alu_rd = '0; bus.alu_data = DW'($urandom());
    bus.mem_valid = 1'b1; bus.mem_rd = '0; bus.mem_data = DW'($urandom());
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b want 1", bus.mem_ready); end
    step();
    idle_inputs();
    checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b want 0", bus.wb_reg_write); end
    checks++; if (bus.dbg_count !== 3'd0) begin errors++; $display("FAIL rd0_count: got %0d want 0", bus.dbg_count); end
    checks++; if (bus.pending_mask !== zero_mask) begin errors++; $display("FAIL rd0_mask: got %h want 0", bus.pending_mask); end
    bus.mem_valid = 1'b1; bus.mem_rd = '0; bus.mem_data = DW'($urandom());
    step();
    idle_inputs();
    checks++; if (bus.dbg_count !== 3'd0) begin errors++; $display("FAIL rd0_load_count: got %0d want 0", bus.dbg_count); end
    step();
    checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL rd0_load_we: got %b want 0", bus.wb_reg_write); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rd0_err_sticky: got %b want 1", bus.err); end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] al;
    logic [31:0]   m;
    for (int i = 0; i < 3; i++) begin
      al = {RN'($urandom_range(1, (1 << RN) - 1)), DW'($urandom())};
      bus.alu_valid = 1'b1; {bus.alu_rd, bus.alu_data} = al;
      bus.mem_valid = 1'b1; bus.mem_rd = RN'(11 + i); bus.mem_data = DW'($urandom());
      exp_q.push_back(al);
      step();
    end
    m = 32'h0000_3800;
    checks++; if (bus.dbg_count !== 3'd3) begin errors++; $display("FAIL mid_count_pre: got %0d want 3", bus.dbg_count); end
    checks++; if (bus.pending_mask !== m) begin errors++; $display("FAIL mid_mask_pre: got %h want %h", bus.pending_mask, m); end
    rst = 1'b0;
    bus.alu_rd = 5'd4;
    step();
    m = '0;
    checks++; if (bus.dbg_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus.dbg_count); end
    checks++; if (bus.pending_mask !== m) begin errors++; $display("FAIL mid_mask: got %h want 0", bus.pending_mask); end
    checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", bus.wb_reg_write); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", bus.err); end
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", bus.mem_ready); end
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL exp_q_drained: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_basic();
    test_load_single();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
